// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default packet geometry, direction codes and
// the dimension-ordered (XY) route computation used by every input port.
package noc_pkg;

  localparam int DEFAULT_PACKET_W = 55;
  localparam int DEFAULT_DATA_W   = 25;
  localparam int DIR_W            = 3;
  localparam int DEFAULT_DIR_LSB  = DEFAULT_DATA_W;
  localparam int ROUTE_W          = 8;

  localparam logic [DIR_W-1:0] DIR_NONE  = 3'b000;
  localparam logic [DIR_W-1:0] DIR_LOCAL = 3'b001;
  localparam logic [DIR_W-1:0] DIR_NORTH = 3'b010;
  localparam logic [DIR_W-1:0] DIR_EAST  = 3'b011;
  localparam logic [DIR_W-1:0] DIR_SOUTH = 3'b100;
  localparam logic [DIR_W-1:0] DIR_WEST  = 3'b101;

  // X is resolved completely before Y, which keeps XY routing deadlock-free.
  function automatic logic [DIR_W-1:0] xy_route(
    input logic [ROUTE_W-1:0] dest_x,
    input logic [ROUTE_W-1:0] dest_y,
    input logic [ROUTE_W-1:0] cur_x,
    input logic [ROUTE_W-1:0] cur_y
  );
    if (dest_x > cur_x)      return DIR_EAST;
    else if (dest_x < cur_x) return DIR_WEST;
    else if (dest_y > cur_y) return DIR_SOUTH;
    else if (dest_y < cur_y) return DIR_NORTH;
    else                     return DIR_LOCAL;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock packet FIFO shared by the router ports; full/empty are
// registered from the next-state occupancy so they never lag a push or pop.
module noc_sync_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_PACKET_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_next;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + CW'(1);
    else if (pop_ok && !push_ok) count_next = count - CW'(1);
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/noc_input_port_controller.sv
// Router input port: answers the upstream req/gnt handshake, stamps each
// accepted packet with its XY output direction and queues it for the arbiters.
module noc_input_port_controller
  import noc_pkg::*;
#(
  parameter int PACKET_W = DEFAULT_PACKET_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = 4,
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter int CUR_X    = 0,
  parameter int CUR_Y    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqUpStr,
  input  logic [PACKET_W-1:0] PacketIn,
  output logic                gntUpStr,
  output logic                full,
  input  logic                headAck,
  output logic [PACKET_W-1:0] PacketOut,
  output logic                empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]          state;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;
  logic [ROUTE_W-1:0]  dest_x;
  logic [ROUTE_W-1:0]  dest_y;
  logic [DIR_W-1:0]    dir;
  logic [PACKET_W-1:0] stamped;
  logic [PACKET_W-1:0] head;

  assign dest_x = ROUTE_W'(PacketIn[DATA_W+3 +: X_W]);
  assign dest_y = ROUTE_W'(PacketIn[DATA_W+3+X_W +: Y_W]);
  assign dir    = xy_route(dest_x, dest_y, ROUTE_W'(CUR_X), ROUTE_W'(CUR_Y));

  always_comb begin
    stamped                   = PacketIn;
    stamped[DATA_W +: DIR_W] = dir;
  end

  // Decision uses the registered count, so a pop in the same edge cannot free a slot.
  assign push = (state == ST_IDLE) && reqUpStr && (count < CNT_W'(DEPTH));
  assign pop  = headAck && !empty;

  // GRANT swallows the cycle in which upstream is still lowering its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gntUpStr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            gntUpStr <= 1'b1;
            state    <= ST_GRANT;
          end else begin
            gntUpStr <= 1'b0;
          end
        end
        default: begin
          gntUpStr <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  noc_sync_fifo #(
    .WIDTH (PACKET_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (stamped),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Output controllers OR every port together, so an empty port must drive zero.
  assign PacketOut = empty ? '0 : head;

endmodule
